pe_sampler_array: RTL

- Parametrised, pipelined nucleotide substitution sampler for the AliSim evolution datapath. One beat carries N_SITES 2-bit nucleotides (A=00, C=01, G=10, T=11) and a 4x4 transition-probability matrix.
- Each lane selects the matrix row for its current nucleotide and draws a new nucleotide from that row using its own per-lane LFSR.
- Adds valid/ready flow control, backpressure, seeding and a per-beat substitution count.

---
 rtl/pe_sampler_array.sv | 105 ++++++++++
 1 files changed

// File: rtl/pe_sampler_array.sv
// pe_sampler_array: two-stage valid/ready nucleotide substitution sampler.
// Each lane draws its next nucleotide from its matrix row using a private Galois LFSR.
module pe_sampler_array #(
   parameter int          N_SITES = 16,
   parameter int          PW      = 10,
   parameter logic [31:0] SEED    = 32'hACE1_2024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2*N_SITES-1:0]         nucl_alig,
   input  logic [16*PW-1:0]             matrix_P,
   input  logic                         seed_load,
   input  logic [31:0]                  seed,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*N_SITES-1:0]         result,
   output logic [$clog2(N_SITES+1)-1:0] sub_count
);
   localparam int          CW     = $clog2(N_SITES+1);
   localparam int          SW     = PW + 2;
   localparam int          PRW    = 2*PW + 2;
   localparam logic [31:0] GOLDEN = 32'h9E37_79B9;
   localparam logic [31:0] TAPS   = 32'h8020_0003;

   // Lane seeds are spread by the golden-ratio constant; an all-zero LFSR would lock up.
   function automatic logic [31:0] lane_seed(input logic [31:0] base, input int idx);
      logic [31:0] v;
      v = base + 32'(idx) * GOLDEN;
      return (v == 32'h0) ? 32'h1 : v;
   endfunction

   logic                 en, accept, s1_valid;
   logic [2*N_SITES-1:0] draw;
   logic [N_SITES-1:0]   diff;
   logic [CW-1:0]        cnt;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;

   for (genvar i = 0; i < N_SITES; i++) begin : g_lane
      logic [31:0]     lfsr;
      logic [1:0]      in_nuc, nuc, o;
      logic [4*PW-1:0] sel, row;
      logic [PW-1:0]   r;
      logic [SW-1:0]   c0, c1, c2, tot, u;
      logic [PRW-1:0]  prod;
      assign in_nuc = nucl_alig[2*i+:2];
      assign sel    = (in_nuc == 2'd0) ? matrix_P[12*PW+:4*PW] :
                      (in_nuc == 2'd1) ? matrix_P[8*PW+:4*PW]  :
                      (in_nuc == 2'd2) ? matrix_P[4*PW+:4*PW]  : matrix_P[0+:4*PW];
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            lfsr <= lane_seed(SEED, i);
            row  <= '0;
            nuc  <= '0;
            r    <= '0;
         end else begin
            if (seed_load)
               lfsr <= lane_seed(seed, i);
            else if (accept)
               lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
            if (accept) begin
               row <= sel;
               nuc <= in_nuc;
               r   <= lfsr[PW-1:0];
            end
         end
      end
      assign c0   = SW'(row[3*PW+:PW]);
      assign c1   = c0 + SW'(row[2*PW+:PW]);
      assign c2   = c1 + SW'(row[PW+:PW]);
      assign tot  = c2 + SW'(row[0+:PW]);
      assign prod = PRW'(r) * PRW'(tot);
      assign u    = SW'(prod >> PW);
      // Strict compares make empty intervals unselectable; an empty row passes through.
      assign o    = (tot == '0) ? nuc  :
                    (u < c0)    ? 2'd0 :
                    (u < c1)    ? 2'd1 :
                    (u < c2)    ? 2'd2 : 2'd3;
      assign draw[2*i+:2] = o;
      assign diff[i]      = (o != nuc);
   end

   always_comb begin
      cnt = '0;
      for (int k = 0; k < N_SITES; k++) cnt = cnt + CW'(diff[k]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         sub_count <= '0;
      end else if (en) begin
         s1_valid  <= accept;
         out_valid <= s1_valid;
         result    <= draw;
         sub_count <= cnt;
      end
   end
endmodule
